// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//
// Streams raster-order pixels in and produces every fully populated 3x3
// neighbourhood (no padding) for a downstream multiply/tree-sum stage.
// Two line buffers hold the previous two rows. A 3x3 shift register holds
// the current window and slides one column per accepted pixel.
//
// Ports
//   i_clk      single clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_pixel    raster-order input pixel
//   i_valid    i_pixel valid
//   o_ready    block can accept i_pixel (= !o_valid || i_ready)
//   o_window   packed 3x3 window, term k = 3*rr + cc at [WORD_WIDTH*k +: WORD_WIDTH]
//              rr = 0 is the oldest row, cc = 0 is the leftmost column
//   o_valid    o_window valid
//   i_ready    downstream accepts o_window
//   o_last     final window of a frame, qualified by o_valid
// -----------------------------------------------------------------------------
module conv_window_gen #(
    parameter int WORD_WIDTH = 8,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [WORD_WIDTH-1:0]     i_pixel,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic [WORD_WIDTH*9-1:0]   o_window,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]          r_col;
    logic [RW-1:0]          r_row;

    logic [WORD_WIDTH-1:0]  r_line0 [IMG_WIDTH];
    logic [WORD_WIDTH-1:0]  r_line1 [IMG_WIDTH];

    logic [WORD_WIDTH-1:0]  r_win      [9];
    logic [WORD_WIDTH-1:0]  w_win_next [9];
    logic [WORD_WIDTH*9-1:0] w_win_packed;

    logic [WORD_WIDTH*9-1:0] r_out_win;
    logic                    r_valid;
    logic                    r_last;

    logic w_accept;
    logic w_emit;
    logic w_col_end;
    logic w_row_end;

    assign o_ready  = !r_valid || i_ready;
    assign w_accept = i_valid && o_ready;

    assign w_col_end = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_end = (r_row == RW'(IMG_HEIGHT - 1));

    // Columns 0..1 of a row still hold stale data from the previous row (or
    // frame) in the window register, so only col >= 2 and row >= 2 emit.
    assign w_emit = (r_row >= RW'(2)) && (r_col >= CW'(2));

    // Window after the shift implied by the pixel being accepted now.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_win_next[k] = '0;
        end
        for (int rr = 0; rr < 3; rr++) begin
            w_win_next[3*rr + 0] = r_win[3*rr + 1];
            w_win_next[3*rr + 1] = r_win[3*rr + 2];
        end
        w_win_next[2] = r_line1[r_col];
        w_win_next[5] = r_line0[r_col];
        w_win_next[8] = i_pixel;
    end

    always_comb begin
        w_win_packed = '0;
        for (int k = 0; k < 9; k++) begin
            w_win_packed[WORD_WIDTH*k +: WORD_WIDTH] = w_win_next[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                if (w_row_end) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers are not reset: every entry is rewritten before it can
    // contribute to an emitted window within the current frame.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_line1[r_col] <= r_line0[r_col];
            r_line0[r_col] <= i_pixel;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= w_win_next[k];
            end
        end
    end

    // Output stage. While o_valid && !i_ready, o_ready is low so nothing is
    // accepted and the registers hold by construction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_win <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end else if (w_accept && w_emit) begin
            r_out_win <= w_win_packed;
            r_valid   <= 1'b1;
            r_last    <= w_row_end && w_col_end;
        end else if (i_ready) begin
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end
    end

    assign o_window = r_out_win;
    assign o_valid  = r_valid;
    assign o_last   = r_last;

endmodule

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
//
// Two instances: a 4x4 image instance for the handshake, multi-frame and
// reset scenarios, and a default 8x8 instance for the continuous-stream case.
// Expected windows are derived directly from the pixel array of each frame.
// -----------------------------------------------------------------------------
module tb_conv_window_gen;

    localparam int WW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 4x4 instance
    logic [WW-1:0]   a_pixel;
    logic            a_valid;
    logic            a_ready;
    logic [WW*9-1:0] a_win;
    logic            a_ovalid;
    logic            a_iready = 1'b1;
    logic            a_last;

    // 8x8 instance
    logic [WW-1:0]   b_pixel;
    logic            b_valid;
    logic            b_ready;
    logic [WW*9-1:0] b_win;
    logic            b_ovalid;
    logic            b_iready;
    logic            b_last;

    conv_window_gen #(.WORD_WIDTH(WW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_pixel  (a_pixel),
        .i_valid  (a_valid),
        .o_ready  (a_ready),
        .o_window (a_win),
        .o_valid  (a_ovalid),
        .i_ready  (a_iready),
        .o_last   (a_last)
    );

    conv_window_gen #(.WORD_WIDTH(WW)) u_dut8 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_pixel  (b_pixel),
        .i_valid  (b_valid),
        .o_ready  (b_ready),
        .o_window (b_win),
        .o_valid  (b_ovalid),
        .i_ready  (b_iready),
        .o_last   (b_last)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: every window whose bottom-right pixel lies at
    // row >= 2, col >= 2, terms taken straight from the frame array.
    int          pix [64];
    logic [72:0] q4 [$];
    logic [72:0] q8 [$];

    task automatic model(input int w, input int h, input bit to8);
        logic [72:0] e;
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                e = '0;
                for (int k = 0; k < 9; k++) begin
                    e[WW*k +: WW] = WW'(pix[(r - 2 + k / 3) * w + (c - 2 + k % 3)]);
                end
                e[72] = (r == h - 1) && (c == w - 1);
                if (to8) q8.push_back(e);
                else     q4.push_back(e);
            end
        end
    endtask

    // i_ready control for the 4x4 instance: 0 = always high, 1 = random,
    // 2 = follow man_rdy.
    int rdy_mode = 0;
    bit man_rdy  = 1'b1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       a_iready = 1'b1;
            1:       a_iready = 1'($urandom_range(0, 1));
            default: a_iready = man_rdy;
        endcase
    end

    // Monitor
    logic [72:0] log4 [$];
    logic [72:0] ref_log [$];
    logic [73:0] hold_v;
    bit          stalled = 1'b0;
    int          cyc = 0;
    int          acc4 = 0;
    int          cnt8 = 0;
    int          first8 = 0;
    int          last8 = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("ready4", a_ready, !a_ovalid || a_iready);
            if (stalled) chk("hold4", {a_ovalid, a_last, a_win}, hold_v);
            stalled = a_ovalid && !a_iready;
            hold_v  = {a_ovalid, a_last, a_win};
            if (a_valid && a_ready) acc4++;
            if (a_ovalid && a_iready) begin
                log4.push_back({a_last, a_win});
                if (q4.size() == 0) chk("extra4", 1, 0);
                else                chk("win4", {a_last, a_win}, q4.pop_front());
            end
            if (b_ovalid && b_iready) begin
                if (cnt8 == 0) first8 = cyc;
                last8 = cyc;
                cnt8++;
                if (q8.size() == 0) chk("extra8", 1, 0);
                else                chk("win8", {b_last, b_win}, q8.pop_front());
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send4(input int v);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        a_pixel = WW'(v);
        a_valid = 1'b1;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = a_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
        a_valid = 1'b0;
    endtask

    task automatic run_frame4(input int base, input bit rnd, input int gap_max);
        for (int i = 0; i < 16; i++) begin
            pix[i] = rnd ? int'($urandom_range(0, 255)) : base + i;
        end
        model(4, 4, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send4(pix[i]);
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((q4.size() != 0 || q8.size() != 0) && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "_q4_left"}, q4.size(), 0);
        chk({tag, "_q8_left"}, q8.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic cmp_ref(input string tag);
        chk({tag, "_count"}, log4.size(), ref_log.size());
        for (int i = 0; i < ref_log.size(); i++) begin
            chk({tag, "_seq"}, (i < log4.size()) ? log4[i] : 73'h0, ref_log[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int acc_before;
        rst_n   = 1'b0;
        a_pixel = '0;
        a_valid = 1'b0;
        b_pixel = '0;
        b_valid = 1'b0;
        b_iready = 1'b1;
        #12;
        chk("rst_valid4", a_ovalid, 0);
        chk("rst_last4",  a_last,   0);
        chk("rst_win4",   a_win,    0);
        chk("rst_ready4", a_ready,  1);
        chk("rst_valid8", b_ovalid, 0);
        chk("rst_win8",   b_win,    0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic 4x4 frame, continuous handshake
        rdy_mode = 0;
        log4.delete();
        run_frame4(0, 1'b0, 0);
        drain("t1");
        chk("t1_count", log4.size(), 4);
        chk("t1_first", log4.size() > 0 ? log4[0] : 73'h0, 73'h0_0a0908_060504_020100);
        chk("t1_last",  log4.size() > 3 ? log4[3] : 73'h0, 73'h1_0f0e0d_0b0a09_070605);
        ref_log = log4;

        // Downstream stall for 5 cycles while a window is pending
        rdy_mode = 2;
        man_rdy  = 1'b1;
        log4.delete();
        fork
            run_frame4(0, 1'b0, 0);
            begin
                t = 0;
                @(negedge clk);
                while (!a_ovalid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                chk("t2_valid_seen", a_ovalid, 1);
                man_rdy = 1'b0;
                @(posedge clk);
                #1;
                acc_before = acc4;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("t2_stall_ready", a_ready, 0);
                    chk("t2_stall_valid", a_ovalid, 1);
                    if (i == 4) man_rdy = 1'b1;
                end
                chk("t2_no_accept", acc4, acc_before);
            end
        join
        drain("t2");
        cmp_ref("t2");

        // Random input gaps and random downstream ready
        rdy_mode = 1;
        log4.delete();
        run_frame4(0, 1'b0, 2);
        drain("t3");
        cmp_ref("t3");
        run_frame4(0, 1'b1, 2);
        drain("t3r");

        // Two frames back to back
        rdy_mode = 0;
        log4.delete();
        run_frame4(0, 1'b0, 0);
        run_frame4(100, 1'b0, 0);
        drain("t4");
        chk("t4_count", log4.size(), 8);
        chk("t4_f2_first", log4.size() > 4 ? log4[4] : 73'h0, 73'h0_6e6d6c_6a6968_666564);
        for (int i = 0; i < 8; i++) begin
            chk("t4_last_flag", i < log4.size() ? log4[i][72] : 1'bx, (i == 3) || (i == 7));
        end

        // Reset after 7 accepted pixels, then a full frame
        for (int i = 0; i < 7; i++) send4(200 + i);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("t5_rst_valid", a_ovalid, 0);
        chk("t5_rst_last",  a_last,   0);
        chk("t5_rst_win",   a_win,    0);
        @(posedge clk);
        #1;
        chk("t5_rst_valid_clk", a_ovalid, 0);
        rst_n = 1'b1;
        log4.delete();
        run_frame4(0, 1'b0, 0);
        drain("t5");
        cmp_ref("t5");

        // Default 8x8 frame, continuous stream
        for (int i = 0; i < 64; i++) pix[i] = i;
        model(8, 8, 1'b1);
        cnt8 = 0;
        for (int i = 0; i < 64; i++) begin
            b_pixel = WW'(i);
            b_valid = 1'b1;
            @(negedge clk);
            chk("t6_ready8", b_ready, 1);
            @(posedge clk);
            #1;
        end
        b_valid = 1'b0;
        drain("t6");
        chk("t6_count8", cnt8, 36);
        chk("t6_span8", last8 - first8, 45);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
